// File: rtl/pipe_stage_skid.sv
// Stallable, flushable pipeline stage register with valid/ready handshake.
// SKID=1 adds a second entry so in_ready is a pure state decode; SKID=0 is a single register.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 133,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q;
  logic   accept, load_main, load_skid, main_from_skid;

  generate
    if (SKID != 0) begin : g_skid
      // Registered decode: no combinational path from out_ready.
      assign in_ready = (state != FULL);
    end else begin : g_noskid
      assign in_ready = (state == EMPTY) || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          // Only reachable with SKID=1; SKID=0 accepts in ONE only when out_ready.
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (out_ready) begin
        state_nxt      = ONE;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; data registers keep their old contents.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main)           main_q <= '{ctrl: in_ctrl, data: in_data};
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= '{ctrl: in_ctrl, data: in_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q.data;
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign occupancy = state;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, a flush, and a saturating stall counter. It replaces the fixed-field, always-advancing inter-stage registers (e.g. MEM→WB) wherever a stage must be able to stall or be flushed. Payload is split into a data field, which holds its last value when empty, and a control field, which is forced to zero when empty so that bubbles never write architectural state.

## Interface
Parameters:
- DATA_W, 133, data payload width (instruction, ALU result, read data, PC+4, rd).
- CTRL_W, 3, control payload width (regWrite, resultSrc); zeroed on bubbles.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready path.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous flush; discards all held and incoming entries.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control payload; 0 whenever out_valid=0.
- occupancy  out  2  number of held entries (0–2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Transfer-in: in_valid && in_ready. Transfer-out: out_valid && out_ready.
- States, SKID=1: EMPTY (occupancy 0), ONE (main valid), FULL (main + skid valid).
- EMPTY: accept → ONE, main←in.
- ONE, accept && out_ready → ONE, main←in.
- ONE, accept && !out_ready → FULL, skid←in.
- ONE, !accept && out_ready → EMPTY.
- ONE, otherwise → hold.
- FULL: in_ready=0. out_ready → ONE, main←skid. Otherwise hold.
- SKID=1: in_ready = (state != FULL). It is a registered decode only, with no path from out_ready.
- SKID=0: only EMPTY/ONE exist. in_ready = !main_valid || out_ready (combinational). Accept && out_ready replaces main.
- out_valid = main valid. out_data = main data. out_ctrl = main ctrl when valid, else 0.
- Data field retains its last value when EMPTY. The skid data register is loaded only on entry to FULL.
- flush: next state EMPTY from any state, with priority over every transition. An input accepted in the flush cycle is dropped. A transfer-out in the flush cycle still completes (downstream has already taken it).
- stall_cnt: increments when out_valid && !out_ready, holds at 2^CNT_W−1, and is not cleared by flush.
- Reset (reset=0, asynchronous): state EMPTY. All data, ctrl and stall_cnt registers are 0. Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0. in_ready=1 (SKID=1) or 1 (SKID=0, since main is invalid).
- Reset is honoured mid-operation in any state; held entries are lost.

## Timing
- Latency: 1 cycle from transfer-in to out_valid, when the stage was EMPTY or ONE with out_ready=1.
- Throughput: 1 transfer/cycle sustained when out_ready is held high.
- SKID=1: after out_ready falls, at most one further entry is accepted. in_ready falls the cycle after entry to FULL is registered. in_ready rises the cycle after FULL drains to ONE.
- Flush: out_valid=0 and out_ctrl=0 in the cycle after flush is sampled. in_ready=1 the same cycle.
- Reset release: the first transfer-in is possible on the first rising edge with reset=1.

## Test plan
- Streaming: SKID=1, out_ready=1, 8 back-to-back inputs with in_data=0..7 and in_ctrl=3'b101 → outputs 0..7 each 1 cycle later, no gaps, occupancy=1, stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → occupancy 1→2, in_ready=0 from cycle 2, stall_cnt=3. After release, order is preserved and no entry is lost or duplicated.
- Flush in FULL with simultaneous in_valid → next cycle out_valid=0, out_ctrl=0, out_data unchanged, occupancy=0. The accepted input is not emitted; stall_cnt is retained.
- Bubble control: EMPTY stage with prior ctrl=3'b111 → out_ctrl=0 while out_valid=0. A regWrite bit never appears with out_valid=0.
- Async reset mid-FULL (deassert clk edges, pulse reset low) → all outputs 0 immediately, in_ready=1. Operation is normal after release.
- SKID=0 and CNT_W=2: out_ready toggling → in_ready follows out_ready combinationally in the same cycle. A 5-cycle stall saturates stall_cnt at 3.
